morse_char_decoder: RTL

- Stage directly downstream of separator_main.
- Accepts each completed 10-bit encoded Morse sequence plus word-space events, and decodes each to an 8-bit ASCII character.
- Queues the characters in a small FIFO for the display/UART consumer.
- Flags unknown or malformed patterns, dropped inputs and buffer overflow.

---
 rtl/morse_char_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/morse_char_decoder.sv
// Morse sequence decoder: turns 10-bit slot-encoded sequences and word-gap strobes
// into ASCII characters queued in a show-ahead FIFO for the downstream consumer.
module morse_char_decoder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [9:0]    seq_in,
    input  logic          seq_valid,
    input  logic          space_in,
    input  logic          Clear,
    input  logic          rd_en,
    output logic [7:0]    char_out,
    output logic          char_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          err_pulse,
    output logic          drop_pulse,
    output logic          overflow
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [7:0]  LP_QMARK = 8'h3F;
    localparam logic [7:0]  LP_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITE,
        ST_WRITE_SP
    } state_t;

    // Symbols are gathered as a length plus a dash=1 bit string, first symbol
    // most significant; anything outside the ITU letter/digit set becomes '?'.
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [2:0] len;
        logic [4:0] code;
        logic       bad;
        logic       seen_empty;
        logic [1:0] sym;
        logic [7:0] ch;
        len        = 3'd0;
        code       = 5'd0;
        bad        = 1'b0;
        seen_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sym = s[9-2*i -: 2];
            if (sym == 2'b11) begin
                bad = 1'b1;
            end else if (sym == 2'b00) begin
                seen_empty = 1'b1;
            end else begin
                if (seen_empty) bad = 1'b1;
                len  = len + 3'd1;
                code = {code[3:0], sym == 2'b10};
            end
        end
        case ({len, code})
            8'b010_00001: ch = 8'h41; // A
            8'b100_01000: ch = 8'h42; // B
            8'b100_01010: ch = 8'h43; // C
            8'b011_00100: ch = 8'h44; // D
            8'b001_00000: ch = 8'h45; // E
            8'b100_00010: ch = 8'h46; // F
            8'b011_00110: ch = 8'h47; // G
            8'b100_00000: ch = 8'h48; // H
            8'b010_00000: ch = 8'h49; // I
            8'b100_00111: ch = 8'h4A; // J
            8'b011_00101: ch = 8'h4B; // K
            8'b100_00100: ch = 8'h4C; // L
            8'b010_00011: ch = 8'h4D; // M
            8'b010_00010: ch = 8'h4E; // N
            8'b011_00111: ch = 8'h4F; // O
            8'b100_00110: ch = 8'h50; // P
            8'b100_01101: ch = 8'h51; // Q
            8'b011_00010: ch = 8'h52; // R
            8'b011_00000: ch = 8'h53; // S
            8'b001_00001: ch = 8'h54; // T
            8'b011_00001: ch = 8'h55; // U
            8'b100_00001: ch = 8'h56; // V
            8'b011_00011: ch = 8'h57; // W
            8'b100_01001: ch = 8'h58; // X
            8'b100_01011: ch = 8'h59; // Y
            8'b100_01100: ch = 8'h5A; // Z
            8'b101_11111: ch = 8'h30; // 0
            8'b101_01111: ch = 8'h31; // 1
            8'b101_00111: ch = 8'h32; // 2
            8'b101_00011: ch = 8'h33; // 3
            8'b101_00001: ch = 8'h34; // 4
            8'b101_00000: ch = 8'h35; // 5
            8'b101_10000: ch = 8'h36; // 6
            8'b101_11000: ch = 8'h37; // 7
            8'b101_11100: ch = 8'h38; // 8
            8'b101_11110: ch = 8'h39; // 9
            default:      ch = LP_QMARK;
        endcase
        if (bad) ch = LP_QMARK;
        return ch;
    endfunction

    state_t       r_state;
    logic [9:0]   r_seq_p0;
    logic [7:0]   r_char_p1;
    logic         r_pend_sp;
    logic         r_drop;

    logic [7:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]  r_count;
    logic         r_overflow;

    logic         w_push;
    logic [7:0]   w_push_data;
    logic         w_pop;
    logic         w_wr;

    // Stage p0: capture the sequence; p1: decoded character; then FIFO write.
    always_ff @(posedge clk) begin
        if (!Reset || Clear) begin
            r_state   <= ST_IDLE;
            r_pend_sp <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= (r_state != ST_IDLE) && (seq_valid || space_in);
            case (r_state)
                ST_IDLE: begin
                    if (seq_valid && (seq_in != 10'd0)) begin
                        r_seq_p0  <= seq_in;
                        r_pend_sp <= space_in;
                        r_state   <= ST_LOOKUP;
                    end else if (space_in) begin
                        r_state <= ST_WRITE_SP;
                    end
                end
                ST_LOOKUP: begin
                    r_char_p1 <= decode(r_seq_p0);
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= r_pend_sp ? ST_WRITE_SP : ST_IDLE;
                end
                ST_WRITE_SP: begin
                    r_pend_sp <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push      = (r_state == ST_WRITE) || (r_state == ST_WRITE_SP);
        w_push_data = (r_state == ST_WRITE) ? r_char_p1 : LP_SPACE;
        w_pop       = rd_en && (r_count != '0);
        // A push into a full FIFO only lands when a pop frees the slot this cycle.
        w_wr        = w_push && ((r_count != LP_DEPTH) || w_pop);
    end

    always_ff @(posedge clk) begin
        if (!Reset || Clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
            if (w_push && !w_wr) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset && !Clear && w_wr) r_mem[r_wr_ptr] <= w_push_data;
    end

    assign char_out   = (r_count == '0) ? 8'h00 : r_mem[r_rd_ptr];
    assign char_valid = (r_count != '0);
    assign count      = r_count;
    assign full       = (r_count == LP_DEPTH);
    assign busy       = (r_state != ST_IDLE);
    assign err_pulse  = (r_state == ST_WRITE) && (r_char_p1 == LP_QMARK);
    assign drop_pulse = r_drop;
    assign overflow   = r_overflow;

endmodule
